// File: rtl/dac_thermometer_decoder.sv
// Receive-side thermometer decoder for the DAC loopback path.
// Undoes the encoder's quarter rotation, bubble-corrects the thermometer
// word, counts its ones and rebuilds the binary sample. Any beat whose
// de-rotated word is not a clean thermometer code is flagged and counted.

module dac_thermometer_decoder #(
    parameter int INPUT_WIDTH       = 10,
    parameter int THERMOMETER_WIDTH = 8,
    parameter int ERR_COUNT_WIDTH   = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       valid_i,
    input  logic [1:0]                                 rotation_i,
    input  logic [(2**THERMOMETER_WIDTH)-1:0]          input_thermometer_i,
    input  logic [INPUT_WIDTH-THERMOMETER_WIDTH-1:0]   input_binary_i,
    input  logic                                       clear_errors_i,
    output logic                                       valid_o,
    output logic [INPUT_WIDTH-1:0]                     output_binary_o,
    output logic                                       bubble_error_o,
    output logic [ERR_COUNT_WIDTH-1:0]                 error_count_o
);

    localparam int L     = 2**THERMOMETER_WIDTH;
    localparam int Q     = L / 4;
    localparam int LSB_W = INPUT_WIDTH - THERMOMETER_WIDTH;
    localparam int CNT_W = THERMOMETER_WIDTH + 1;

    // Stage 1 registers
    logic             s1_valid;
    logic [L-1:0]     s1_therm;
    logic [1:0]       s1_rot;
    logic [LSB_W-1:0] s1_lsb;

    // Stage 2 registers
    logic             s2_valid;
    logic [L-1:0]     s2_corr;
    logic             s2_err;
    logic [LSB_W-1:0] s2_lsb;

    // Stage 2 combinational results
    logic [L-1:0]     derot;
    logic [L+1:0]     derot_ext;
    logic [L-1:0]     corrected;
    logic             code_err;

    // Stage 3 combinational results
    logic [CNT_W-1:0] ones_count;
    logic [CNT_W-1:0] sat_count;

    // Valid pipeline: the only state besides outputs that reset must clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= valid_i;
            s2_valid <= s1_valid;
        end
    end

    // Stage 1 data capture, only on a qualified input beat
    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            s1_therm <= input_thermometer_i;
            s1_rot   <= rotation_i;
            s1_lsb   <= input_binary_i;
        end
    end

    // De-rotate: rotate right by rotation * L/4 to undo the encoder's left rotation
    always_comb begin
        derot = s1_therm;
        case (s1_rot)
            2'd0: derot = s1_therm;
            2'd1: derot = {s1_therm[Q-1:0],   s1_therm[L-1:Q]};
            2'd2: derot = {s1_therm[2*Q-1:0], s1_therm[L-1:2*Q]};
            2'd3: derot = {s1_therm[3*Q-1:0], s1_therm[L-1:3*Q]};
            default: derot = s1_therm;
        endcase
    end

    // Flag any 0-to-1 step going upward, or a set top bit (count would overflow L-1)
    always_comb begin
        code_err = derot[L-1];
        for (int k = 0; k < L-1; k++) begin
            if (!derot[k] && derot[k+1]) begin
                code_err = 1'b1;
            end
        end
    end

    // Three-tap majority vote; the word is padded with a 1 below and a 0 above
    always_comb begin
        derot_ext = {1'b0, derot, 1'b1};
        corrected = '0;
        for (int k = 0; k < L; k++) begin
            corrected[k] = (derot_ext[k]   & derot_ext[k+1]) |
                           (derot_ext[k]   & derot_ext[k+2]) |
                           (derot_ext[k+1] & derot_ext[k+2]);
        end
    end

    // Stage 2 data capture, following the stage 1 valid bit
    always_ff @(posedge clk_i) begin
        if (s1_valid) begin
            s2_corr <= corrected;
            s2_err  <= code_err;
            s2_lsb  <= s1_lsb;
        end
    end

    // Popcount of the corrected word, clamped so an all-ones word reads L-1
    always_comb begin
        ones_count = '0;
        for (int k = 0; k < L; k++) begin
            ones_count = ones_count + CNT_W'(s2_corr[k]);
        end
        sat_count = ones_count;
        if (ones_count > CNT_W'(L-1)) begin
            sat_count = CNT_W'(L-1);
        end
    end

    // Output stage: the sample holds between beats, the error flag never outlives valid
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o         <= 1'b0;
            output_binary_o <= '0;
            bubble_error_o  <= 1'b0;
        end else begin
            valid_o        <= s2_valid;
            bubble_error_o <= s2_valid & s2_err;
            if (s2_valid) begin
                output_binary_o <= {sat_count[THERMOMETER_WIDTH-1:0], s2_lsb};
            end
        end
    end

    // Saturating error counter; clear wins over a simultaneous increment
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_count_o <= '0;
        end else if (clear_errors_i) begin
            error_count_o <= '0;
        end else if (s2_valid && s2_err && (error_count_o != {ERR_COUNT_WIDTH{1'b1}})) begin
            error_count_o <= error_count_o + 1'b1;
        end
    end

endmodule
